// File: rtl/dma_write_scheduler_if.sv
// Command/handshake bundle between the write scheduler and the DMA write engine.
// The scheduler drives the command side and the engine returns ready and completion.
interface dma_write_scheduler_if;
   logic [31:0] dma_da_config;
   logic [25:0] dma_length_config;
   logic        dma_write_valid;
   logic        dma_write_idle;
   logic        dma_write_int;

   modport master (
      output dma_da_config,
      output dma_length_config,
      output dma_write_valid,
      input  dma_write_idle,
      input  dma_write_int
   );

   modport slave (
      input  dma_da_config,
      input  dma_length_config,
      input  dma_write_valid,
      output dma_write_idle,
      output dma_write_int
   );
endinterface

// File: rtl/dma_write_scheduler.sv
// Splits a DMA write job into engine-sized chunks, one command per completion interrupt,
// with abort handling and a per-chunk completion watchdog.
module dma_write_scheduler #(
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int CNT_W          = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  job_start,
   input  logic [31:0]           job_base_addr,
   input  logic [31:0]           job_total_len,
   input  logic [25:0]           chunk_len,
   input  logic                  job_abort,
   dma_write_scheduler_if.master dma,
   output logic                  job_busy,
   output logic                  job_done,
   output logic                  job_error,
   output logic                  job_aborted,
   output logic [CNT_W-1:0]      chunks_issued
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_r;
   logic [31:0]      addr_r;
   logic [31:0]      remain_r;
   logic [25:0]      clen_r;
   logic [25:0]      len_r;
   logic             valid_r;
   logic             busy_r;
   logic             done_r;
   logic             error_r;
   logic             aborted_r;
   logic             abort_pend_r;
   logic             int_prev_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WD_W-1:0]  wd_r;

   logic             accept_s;
   logic             comp_s;
   logic             stop_s;
   logic [31:0]      len_ext_s;

   // Next command length: the remaining bytes, capped at the job's chunk size.
   function automatic logic [25:0] chunk_min(input logic [31:0] remain, input logic [25:0] clen);
      if (remain < {6'd0, clen}) begin
         chunk_min = remain[25:0];
      end else begin
         chunk_min = clen;
      end
   endfunction

   assign accept_s  = valid_r & dma.dma_write_idle;
   assign comp_s    = dma.dma_write_int & ~int_prev_r;
   assign stop_s    = abort_pend_r | job_abort;
   assign len_ext_s = {6'd0, len_r};

   // Job sequencer: latches the job, issues chunks, tracks completion, abort and timeout.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r      <= S_IDLE;
         addr_r       <= 32'd0;
         remain_r     <= 32'd0;
         clen_r       <= 26'd0;
         len_r        <= 26'd0;
         valid_r      <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         aborted_r    <= 1'b0;
         abort_pend_r <= 1'b0;
         int_prev_r   <= 1'b0;
         cnt_r        <= '0;
         wd_r         <= '0;
      end else begin
         int_prev_r <= dma.dma_write_int;
         done_r     <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (job_start) begin
                  addr_r       <= job_base_addr;
                  remain_r     <= job_total_len;
                  clen_r       <= chunk_len;
                  error_r      <= 1'b0;
                  aborted_r    <= 1'b0;
                  abort_pend_r <= 1'b0;
                  cnt_r        <= '0;
                  wd_r         <= '0;
                  busy_r       <= 1'b1;
                  if ((job_total_len == 32'd0) || (chunk_len == 26'd0)) begin
                     state_r <= S_DONE;
                  end else begin
                     len_r   <= chunk_min(job_total_len, chunk_len);
                     valid_r <= 1'b1;
                     state_r <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // An accept in the same cycle as abort wins; the abort is carried into the wait.
               if (accept_s) begin
                  valid_r      <= 1'b0;
                  cnt_r        <= cnt_r + CNT_W'(1);
                  addr_r       <= addr_r + len_ext_s;
                  remain_r     <= remain_r - len_ext_s;
                  wd_r         <= '0;
                  abort_pend_r <= job_abort;
                  state_r      <= S_WAIT;
               end else if (job_abort) begin
                  valid_r   <= 1'b0;
                  aborted_r <= 1'b1;
                  state_r   <= S_DONE;
               end
            end
            S_WAIT: begin
               if (job_abort) begin
                  abort_pend_r <= 1'b1;
               end
               if (comp_s) begin
                  if (stop_s || (remain_r == 32'd0)) begin
                     aborted_r <= stop_s;
                     state_r   <= S_DONE;
                  end else begin
                     len_r   <= chunk_min(remain_r, clen_r);
                     valid_r <= 1'b1;
                     state_r <= S_ISSUE;
                  end
               end else if (wd_r == WD_LAST) begin
                  error_r <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  wd_r <= wd_r + WD_W'(1);
               end
            end
            S_DONE: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               valid_r <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign dma.dma_da_config     = addr_r;
   assign dma.dma_length_config = len_r;
   assign dma.dma_write_valid   = valid_r;
   assign job_busy              = busy_r;
   assign job_done              = done_r;
   assign job_error             = error_r;
   assign job_aborted           = aborted_r;
   assign chunks_issued         = cnt_r;

endmodule

// File: tb/tb_dma_write_scheduler.sv
// Scoreboard bench for dma_write_scheduler: expected engine commands are queued per job
// and checked by a monitor at every accepted command; job status is checked directly.
module tb_dma_write_scheduler;

   localparam int TO = 16;

   typedef struct {
      logic [31:0] addr;
      logic [25:0] len;
   } cmd_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        job_start = 1'b0;
   logic [31:0] job_base_addr = 32'd0;
   logic [31:0] job_total_len = 32'd0;
   logic [25:0] chunk_len = 26'd0;
   logic        job_abort = 1'b0;
   logic        job_busy, job_done, job_error, job_aborted;
   logic [15:0] chunks_issued;

   dma_write_scheduler_if bus ();

   dma_write_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .job_start     (job_start),
      .job_base_addr (job_base_addr),
      .job_total_len (job_total_len),
      .chunk_len     (chunk_len),
      .job_abort     (job_abort),
      .dma           (bus),
      .job_busy      (job_busy),
      .job_done      (job_done),
      .job_error     (job_error),
      .job_aborted   (job_aborted),
      .chunks_issued (chunks_issued)
   );

   always #5 CLK = ~CLK;

   cmd_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   acc_cyc = 0;
   int   done_total = 0;
   int   eng_delay = 5;
   logic eng_no_int = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_cmd(input logic [31:0] a, input logic [25:0] l);
      cmd_t c;
      c.addr = a;
      c.len  = l;
      exp_q.push_back(c);
   endtask

   // Called at a falling edge; returns one cycle later with job_start dropped.
   task automatic start_job(input logic [31:0] b, input logic [31:0] t, input logic [25:0] c);
      job_base_addr = b;
      job_total_len = t;
      chunk_len     = c;
      job_start     = 1'b1;
      @(negedge CLK);
      job_start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (job_done === 1'b1) begin
            dcyc = cyc;
            break;
         end
      end
      chk("done_within_budget", (dcyc >= 0), 1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   // Monitor: pops the scoreboard on every accepted command.
   initial begin
      cmd_t e;
      forever begin
         @(posedge CLK);
         cyc++;
         if (RST === 1'b0 && bus.dma_write_valid === 1'b1 && bus.dma_write_idle === 1'b1) begin
            acc_cnt++;
            acc_cyc = cyc;
            chk("sb_has_entry", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("cmd_addr", bus.dma_da_config, e.addr);
               chk("cmd_len", bus.dma_length_config, e.len);
            end
         end
      end
   end

   // Engine model: one-cycle interrupt pulse eng_delay cycles after each accept.
   initial begin
      int cd = 0;
      int seen = 0;
      bus.dma_write_int = 1'b0;
      forever begin
         @(negedge CLK);
         if (bus.dma_write_int) bus.dma_write_int = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) bus.dma_write_int = 1'b1;
         end
         if (acc_cnt != seen) begin
            seen = acc_cnt;
            if (!eng_no_int) cd = eng_delay;
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (job_done === 1'b1) done_total++;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time limit");
   end

   initial begin
      int d0, a0, dcyc, ok;
      bus.dma_write_idle = 1'b1;
      idle_cycles(3);

      // Reset state
      chk("rst_valid", bus.dma_write_valid, 0);
      chk("rst_addr", bus.dma_da_config, 0);
      chk("rst_len", bus.dma_length_config, 0);
      chk("rst_busy", job_busy, 0);
      chk("rst_done", job_done, 0);
      chk("rst_error", job_error, 0);
      chk("rst_aborted", job_aborted, 0);
      chk("rst_chunks", chunks_issued, 0);
      RST = 1'b0;
      idle_cycles(2);

      // 0x800 bytes in 0x40 chunks
      d0 = done_total;
      for (int i = 0; i < 32; i++) push_cmd(32'h40 * i, 26'h40);
      start_job(32'h0, 32'h800, 26'h40);
      chk("t1_busy", job_busy, 1);
      chk("t1_first_valid", bus.dma_write_valid, 1);
      wait_done(2000, dcyc);
      chk("t1_chunks", chunks_issued, 32);
      chk("t1_error", job_error, 0);
      idle_cycles(3);
      chk("t1_done_count", done_total - d0, 1);
      chk("t1_busy_after", job_busy, 0);
      chk("t1_sb_empty", exp_q.size(), 0);

      // Remainder chunk: 0x90 = 0x40 + 0x40 + 0x10
      d0 = done_total;
      push_cmd(32'h1000, 26'h40);
      push_cmd(32'h1040, 26'h40);
      push_cmd(32'h1080, 26'h10);
      start_job(32'h1000, 32'h90, 26'h40);
      wait_done(200, dcyc);
      chk("t2_chunks", chunks_issued, 3);
      chk("t2_done_after_int", (dcyc - acc_cyc >= eng_delay + 1), 1);
      idle_cycles(3);
      chk("t2_done_count", done_total - d0, 1);
      chk("t2_sb_empty", exp_q.size(), 0);

      // Zero-length job: no command, done two cycles after start
      d0 = done_total;
      start_job(32'h500, 32'h0, 26'h40);
      chk("t3_valid_n1", bus.dma_write_valid, 0);
      chk("t3_done_n1", job_done, 0);
      @(negedge CLK);
      chk("t3_done_n2", job_done, 1);
      chk("t3_chunks", chunks_issued, 0);
      idle_cycles(3);
      chk("t3_done_count", done_total - d0, 1);

      // Watchdog: engine accepts but never interrupts
      eng_no_int = 1'b1;
      push_cmd(32'h2000, 26'h40);
      start_job(32'h2000, 32'h100, 26'h40);
      wait_done(100, dcyc);
      chk("t4_error", job_error, 1);
      chk("t4_chunks", chunks_issued, 1);
      chk("t4_latency_window", ((dcyc - acc_cyc >= TO - 1) && (dcyc - acc_cyc <= TO + 1)), 1);
      chk("t4_sb_empty", exp_q.size(), 0);
      idle_cycles(2);
      eng_no_int = 1'b0;
      start_job(32'h0, 32'h0, 26'h40);
      chk("t4_error_cleared", job_error, 0);
      wait_done(10, dcyc);
      idle_cycles(2);

      // Abort while the engine refuses the command
      bus.dma_write_idle = 1'b0;
      d0 = done_total;
      start_job(32'h3000, 32'h100, 26'h40);
      chk("t5_valid", bus.dma_write_valid, 1);
      job_abort = 1'b1;
      @(negedge CLK);
      job_abort = 1'b0;
      chk("t5_valid_dropped", bus.dma_write_valid, 0);
      chk("t5_aborted", job_aborted, 1);
      @(negedge CLK);
      chk("t5_done", job_done, 1);
      chk("t5_chunks", chunks_issued, 0);
      bus.dma_write_idle = 1'b1;
      idle_cycles(3);
      chk("t5_done_count", done_total - d0, 1);

      // Abort during the wait for chunk 2
      d0 = done_total;
      a0 = acc_cnt;
      push_cmd(32'h4000, 26'h40);
      push_cmd(32'h4040, 26'h40);
      start_job(32'h4000, 32'h100, 26'h40);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (acc_cnt - a0 >= 2) begin
            ok = 1;
            break;
         end
         @(negedge CLK);
      end
      chk("t6_second_accept", ok, 1);
      job_abort = 1'b1;
      @(negedge CLK);
      job_abort = 1'b0;
      wait_done(100, dcyc);
      chk("t6_done_after_int", (dcyc - acc_cyc >= eng_delay + 1), 1);
      chk("t6_chunks", chunks_issued, 2);
      chk("t6_aborted", job_aborted, 1);
      chk("t6_error", job_error, 0);
      idle_cycles(3);
      chk("t6_done_count", done_total - d0, 1);
      chk("t6_sb_empty", exp_q.size(), 0);

      // Reset while waiting for a completion
      d0 = done_total;
      a0 = acc_cnt;
      push_cmd(32'h5000, 26'h40);
      start_job(32'h5000, 32'h100, 26'h40);
      for (int i = 0; i < 20 && acc_cnt == a0; i++) @(negedge CLK);
      chk("t7_accepted", acc_cnt - a0, 1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("t7_valid", bus.dma_write_valid, 0);
      chk("t7_addr", bus.dma_da_config, 0);
      chk("t7_len", bus.dma_length_config, 0);
      chk("t7_busy", job_busy, 0);
      chk("t7_chunks", chunks_issued, 0);
      idle_cycles(12);
      chk("t7_no_done", done_total - d0, 0);
      chk("t7_still_idle", job_busy, 0);

      // Fresh job after reset
      d0 = done_total;
      push_cmd(32'h6000, 26'h40);
      push_cmd(32'h6040, 26'h40);
      start_job(32'h6000, 32'h80, 26'h40);
      wait_done(200, dcyc);
      chk("t8_chunks", chunks_issued, 2);
      chk("t8_error", job_error, 0);
      chk("t8_aborted", job_aborted, 0);
      idle_cycles(3);
      chk("t8_done_count", done_total - d0, 1);
      chk("t8_sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
